// File: rtl/mem_pkg.sv
// Shared definitions for the banked MEM stage: access-size encodings, FSM states,
// byte-enable generation and load extraction/extension helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } mem_state_e;

    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B:    be_gen = 4'b0001 << off;
            F3_H:    be_gen = 4'b0011 << off;
            F3_W:    be_gen = 4'b1111;
            default: be_gen = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] funct3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (funct3)
            F3_B:    load_ext = {{24{sh[7]}}, sh[7:0]};
            F3_H:    load_ext = {{16{sh[15]}}, sh[15:0]};
            F3_BU:   load_ext = {24'h0, sh[7:0]};
            F3_HU:   load_ext = {16'h0, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

    // Forces the offset to natural alignment when misaligned accesses are not trapped.
    function automatic logic [1:0] align_off(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3[1:0])
            2'b01:   align_off = {off[1], 1'b0};
            2'b10:   align_off = 2'b00;
            default: align_off = off;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// One data-memory bank: BANK_AW x 32 words, byte write enables, and a read path whose
// address is delayed READ_LAT-1 cycles so the stage's capture register completes the latency.
module dmem_bank #(
    parameter int BANK_AW  = 14,
    parameter int READ_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [3:0]         be,
    input  logic [BANK_AW-1:0] waddr,
    input  logic [31:0]        wdata,
    input  logic               re,
    input  logic [BANK_AW-1:0] raddr,
    output logic [31:0]        rdata
);

    logic [31:0]        mem [0:(1 << BANK_AW) - 1];
    logic [BANK_AW-1:0] rd_idx;

    // NOTE: the array has no reset; clearing a RAM needs a sequencer and contents are
    // undefined after power-up anyway.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    if (READ_LAT > 1) begin : g_pipe
        logic [BANK_AW-1:0] pipe_d [READ_LAT-1];
        logic [BANK_AW-1:0] pipe_q [READ_LAT-1];

        always_comb begin
            pipe_d = pipe_q;
            if (re) pipe_d[0] = raddr;
            for (int i = 1; i < READ_LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
        end

        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pipe_q <= '{default: '0};
            else        pipe_q <= pipe_d;
        end

        assign rd_idx = pipe_q[READ_LAT-2];
    end else begin : g_comb
        logic unused_rst;
        assign unused_rst = rst_n;
        assign rd_idx     = re ? raddr : '0;
    end

    assign rdata = mem[rd_idx];

endmodule

// File: rtl/mem_stage_banked.sv
// MEM pipeline stage over NUM_BANKS word-interleaved banks with a load-latency stall FSM.
// Define MEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses instead of masking them.
module mem_stage_banked
    import mem_pkg::*;
#(
    parameter int NUM_BANKS = 4,
    parameter int BANK_AW   = 14,
    parameter int READ_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m_MemRead,
    input  logic        m_MemWrite,
    input  logic [2:0]  m_funct3,
    input  logic        m_JAL,
    input  logic        m_LUI,
    input  logic [31:0] m_alu_out,
    input  logic [31:0] m_mem_data,
    input  logic [31:0] m_imm,
    input  logic [31:0] m_pc_inc,
    output logic        stall_mem,
    output logic [31:0] read_data_MEMWB,
    output logic [31:0] reg_data_MEMWB,
    output logic        misalign_fault
);

    localparam int BSEL_W = $clog2(NUM_BANKS);
    localparam int BSW    = (BSEL_W > 0) ? BSEL_W : 1;
    localparam int CNT_W  = 2;

    logic [1:0]         off_raw;
    logic [1:0]         off;
    logic [BSW-1:0]     bank_sel;
    logic [BANK_AW-1:0] word_idx;
    logic               fault;
    logic               is_load;
    logic               issue;
    logic               we;
    logic [3:0]         be;
    logic [31:0]        wdata;
    logic [31:0]        bank_rdata;
    logic [31:0]        rdata [NUM_BANKS];

    mem_state_e         state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [31:0]        hold_d, hold_q;
    logic               stall_c;

    assign off_raw  = m_alu_out[1:0];
    assign word_idx = m_alu_out[2 + BSEL_W +: BANK_AW];

    if (BSEL_W == 0) begin : g_one_bank
        assign bank_sel   = '0;
        assign bank_rdata = rdata[0];
    end else begin : g_multi_bank
        assign bank_sel   = m_alu_out[2 +: BSW];
        assign bank_rdata = rdata[bank_sel];
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign fault = (m_MemRead | m_MemWrite) & misaligned(m_funct3, off_raw);
    assign off   = off_raw;
`else
    assign fault = 1'b0;
    assign off   = align_off(m_funct3, off_raw);
`endif

    // A simultaneous read and write is treated as a store.
    assign is_load = m_MemRead & ~m_MemWrite;
    assign issue   = (state_q == ST_IDLE) & is_load & ~fault;
    assign we      = m_MemWrite & ~fault & rst_n;
    assign be      = be_gen(m_funct3, off);

    always_comb begin
        case (m_funct3[1:0])
            2'b00:   wdata = {4{m_mem_data[7:0]}};
            2'b01:   wdata = {2{m_mem_data[15:0]}};
            default: wdata = m_mem_data;
        endcase
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        dmem_bank #(
            .BANK_AW  (BANK_AW),
            .READ_LAT (READ_LAT)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (we & (bank_sel == BSW'(b))),
            .be    (be),
            .waddr (word_idx),
            .wdata (wdata),
            .re    (issue & (bank_sel == BSW'(b))),
            .raddr (word_idx),
            .rdata (rdata[b])
        );
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_load && fault) begin
                    hold_d = '0;
                end else if (is_load) begin
                    stall_c = 1'b1;
                    if (READ_LAT == 1) begin
                        hold_d  = load_ext(m_funct3, off, bank_rdata);
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = CNT_W'(READ_LAT - 1);
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hold_d  = load_ext(m_funct3, off, bank_rdata);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Gating with rst_n makes a reset mid-load release the pipeline immediately.
    assign stall_mem       = stall_c & rst_n;
    assign read_data_MEMWB = hold_q;
    assign reg_data_MEMWB  = m_JAL ? m_pc_inc : (m_LUI ? m_imm : m_alu_out);
    assign misalign_fault  = fault;

endmodule

// File: doc/mem_stage_banked.md
# mem_stage_banked

Parametrised memory (MEM) pipeline stage that sits between the EX/MEM and MEM/WB buffers of the CPU. It owns a configurable number of interleaved data-memory banks. It supports byte, halfword and word loads and stores with sign or zero extension, and it supports configurable read latency. A small state machine stalls the pipeline for exactly the read latency.

## Interface
- NUM_BANKS, 4, number of word-interleaved banks; power of two, 1..8
- BANK_AW, 14, word-address width of each bank
- READ_LAT, 1, bank read latency in cycles, 1..4
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m_MemRead  in  1  load in MEM stage
- m_MemWrite  in  1  store in MEM stage
- m_funct3  in  3  RV32 access size/sign: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101
- m_JAL, m_LUI  in  1 each  write-back source select
- m_alu_out  in  32  effective byte address / ALU result
- m_mem_data  in  32  store data (low-aligned)
- m_imm  in  32  LUI immediate
- m_pc_inc  in  32  PC+4 for JAL
- stall_mem  out  1  freeze IF..EX/MEM while high
- read_data_MEMWB  out  32  extended load result
- reg_data_MEMWB  out  32  non-load write-back value
- misalign_fault  out  1  misaligned access flag (see Configuration)

## Operation
- Address split: off = addr[1:0]; bank = addr[2 +: log2(NUM_BANKS)]; word index = next BANK_AW bits. Higher address bits are ignored (aliasing). When NUM_BANKS=1 there is no bank field.
- reg_data_MEMWB is combinational: m_JAL ? m_pc_inc : m_LUI ? m_imm : m_alu_out.
- Stores:
  - Byte enables: SB = 0001<<off, SH = 0011<<off, SW = 1111.
  - Write data is replicated: byte into all 4 lanes, half into both halves.
  - Only the selected bank is written, at the clock edge of the MEM cycle.
  - A store never stalls.
- Loads: the selected bank is read, and the returned word is shifted right by off*8.
  - LB and LH sign-extend from bit 7 and bit 15 respectively.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- Holding register: the result is captured into a holding register that drives read_data_MEMWB. It keeps its value until the next load completes.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with m_MemRead & !m_MemWrite: issue the bank read, load counter = READ_LAT-1, go to BUSY. stall_mem = 1 combinationally in this cycle.
  - BUSY: stall_mem = 1; decrement the counter. At 0, capture the extended data and go to DONE.
  - DONE: stall_mem = 0; read_data_MEMWB is valid; unconditionally return to IDLE. A load is not reissued in this state.
- m_MemRead and m_MemWrite high together is illegal. It is treated as a store: no read, no stall.
- Upstream holds all m_* inputs stable while stall_mem is high.

## Timing
- Reset values: FSM = IDLE, counter = 0, holding register = 0. Hence stall_mem = 0, read_data_MEMWB = 0, misalign_fault = 0. Bank contents are not cleared.
- Load occupancy in MEM: READ_LAT+1 cycles, with stall_mem high for the first READ_LAT of them.
- Stores take 1 cycle. Back-to-back loads get a fresh IDLE→BUSY sequence each.
- Store followed by a load to the same word: the load returns the new data, because the write commits at the edge before the read issues.
- Reset asserted mid-load aborts the load: stall_mem drops asynchronously and no bank write occurs.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - Misaligned accesses are LH/LHU/SH with off[0]=1, and LW/SW with off≠0.
  - Such an access raises misalign_fault combinationally for as long as it is presented.
  - The write is suppressed.
  - A load does not stall, and the holding register is loaded with 0 in that cycle.
- Not defined:
  - misalign_fault is tied 0.
  - The low offset bits are masked to natural alignment: half uses off[1] only, word uses off = 0.

## Structure
- Package mem_pkg holds:
  - funct3 localparams
  - the FSM state enum
  - function be_gen(funct3, off)
  - function load_ext(funct3, off, word)
- Sub-module dmem_bank: a BANK_AW × 32 array with 4 byte-write enables and a READ_LAT-stage read pipeline. It is instantiated NUM_BANKS times in a generate loop.

## Test plan
- Reset:
  - Stimulus: rst_n low, then release with no requests.
  - Required response: stall_mem = 0, read_data_MEMWB = 0, misalign_fault = 0.
- Word store and load:
  - Stimulus: SW 0xDEADBEEF to addr 0x0000_0104, then LW from the same address with READ_LAT = 3.
  - Required response: stall_mem high for exactly 3 cycles, then read_data_MEMWB = 0xDEADBEEF.
- Byte and halfword extension:
  - Stimulus: SW 0x80FF_7F01 to 0x20, then loads: LB 0x23, LBU 0x23, LH 0x22, LHU 0x20.
  - Required response, in order: 0xFFFF_FF80, 0x0000_0080, 0xFFFF_80FF, 0x0000_7F01.
- Bank interleave:
  - Stimulus: NUM_BANKS = 8; SW i to addr 4*i for i = 0..15, then read all 16 back.
  - Required response: every readback is correct, and each write hits only bank i % 8.
- Misalignment:
  - Stimulus: SW to 0x102, in both builds.
  - With MEM_MISALIGN_TRAP_EN: misalign_fault = 1 and memory is unchanged.
  - Without it: fault = 0, and the write lands at word 0x100.
- Write-back mux and reset abort:
  - Stimulus: m_JAL = 1 with m_pc_inc = 0x44; then m_LUI = 1 with m_imm = 0x12345000.
  - Required response: reg_data_MEMWB = 0x44, then 0x12345000.
  - Stimulus: assert rst_n during BUSY.
  - Required response: stall_mem drops immediately and the FSM is in IDLE.
